// File: rtl/apb_timer_event_cond_if.sv
// APB slave bus bundle for the timer event conditioner.
// It carries the APB request signals and the response signals.
interface apb_timer_event_cond_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR_i;
  logic [31:0]               PWDATA_i;
  logic                      PWRITE_i;
  logic                      PSEL_i;
  logic                      PENABLE_i;
  logic [31:0]               PRDATA_o;
  logic                      PREADY_o;
  logic                      PSLVERR_o;

  modport slave (
    input  PADDR_i, PWDATA_i, PWRITE_i, PSEL_i, PENABLE_i,
    output PRDATA_o, PREADY_o, PSLVERR_o
  );

  modport master (
    output PADDR_i, PWDATA_i, PWRITE_i, PSEL_i, PENABLE_i,
    input  PRDATA_o, PREADY_o, PSLVERR_o
  );
endinterface

// File: rtl/apb_timer_event_cond.sv
// Event conditioner for the APB timer's event_lo/event_hi inputs: pin select, 2-flop sync,
// optional glitch filter (TIMER_EVT_FILTER_EN), edge qualification, SW trigger and W1C status.
module apb_timer_event_cond #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_EXT          = 4,
  parameter int FILT_W         = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  apb_timer_event_cond_if.slave apb,
  input  logic [N_EXT-1:0]     ext_evt_i,
  output logic                 event_lo_o,
  output logic                 event_hi_o
);

  localparam logic [3:0] A_CFG_LO = 4'h0;
  localparam logic [3:0] A_CFG_HI = 4'h4;
  localparam logic [3:0] A_SWTRIG = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  logic [3:0]       addr;
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       cfg_wr;
  logic [1:0]       sw_trig;
  logic [1:0]       st_clr;
  logic [1:0]       trans;
  logic [1:0][3:0]  src_q, src_d;
  logic [1:0][1:0]  mode_q, mode_d;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       f_q, f_d;
  logic [1:0][1:0]  warm_q, warm_d;
  logic [1:0]       ev_q, ev_d;
  logic [1:0]       status_q, status_d;
`ifdef TIMER_EVT_FILTER_EN
  logic [1:0][FILT_W-1:0] flen_q, flen_d;
  logic [1:0][FILT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unused_filt_w = FILT_W;
`endif
  logic [31:0]      rdata;
  logic             unused_bits;

  assign addr  = apb.PADDR_i[3:0];
  assign wr_en = apb.PSEL_i & apb.PENABLE_i & apb.PWRITE_i;
  assign rd_en = apb.PSEL_i & ~apb.PWRITE_i;
  assign unused_bits = ^{apb.PADDR_i[APB_ADDR_WIDTH-1:0], apb.PWDATA_i};

  always_comb begin
    src_d    = src_q;
    mode_d   = mode_q;
    s1_d     = '0;
    s2_d     = s1_q;
    f_d      = f_q;
    warm_d   = warm_q;
    status_d = status_q;
    cfg_wr   = '0;
    sw_trig  = '0;
    st_clr   = '0;
    trans    = '0;
    ev_d     = '0;
`ifdef TIMER_EVT_FILTER_EN
    flen_d   = flen_q;
    cnt_d    = cnt_q;
`endif
    for (int ch = 0; ch < 2; ch++) begin
      cfg_wr[ch]  = wr_en && (addr == ((ch == 0) ? A_CFG_LO : A_CFG_HI));
      sw_trig[ch] = wr_en && (addr == A_SWTRIG) && apb.PWDATA_i[ch];
      st_clr[ch]  = wr_en && (addr == A_STATUS) && apb.PWDATA_i[ch];
      if (cfg_wr[ch]) begin
        src_d[ch]  = apb.PWDATA_i[3:0];
        mode_d[ch] = apb.PWDATA_i[5:4];
`ifdef TIMER_EVT_FILTER_EN
        flen_d[ch] = apb.PWDATA_i[8 +: FILT_W];
`endif
      end
      // The first sync flop samples the newly written source so warmup covers the whole chain.
      for (int i = 0; i < N_EXT; i++) begin
        if (src_d[ch] == 4'(i)) s1_d[ch] = ext_evt_i[i];
      end

      if (cfg_wr[ch]) begin
        f_d[ch]    = s2_q[ch];
        warm_d[ch] = 2'd2;
`ifdef TIMER_EVT_FILTER_EN
        cnt_d[ch]  = '0;
`endif
      end else if (warm_q[ch] != 2'd0) begin
        f_d[ch]    = s2_q[ch];
        warm_d[ch] = warm_q[ch] - 2'd1;
`ifdef TIMER_EVT_FILTER_EN
        cnt_d[ch]  = '0;
`endif
      end else if (s2_q[ch] == f_q[ch]) begin
`ifdef TIMER_EVT_FILTER_EN
        cnt_d[ch]  = '0;
`endif
      end else begin
`ifdef TIMER_EVT_FILTER_EN
        if (cnt_q[ch] == flen_q[ch]) begin
          f_d[ch]   = s2_q[ch];
          cnt_d[ch] = '0;
          trans[ch] = 1'b1;
        end else begin
          cnt_d[ch] = cnt_q[ch] + FILT_W'(1);
        end
`else
        f_d[ch]   = s2_q[ch];
        trans[ch] = 1'b1;
`endif
      end

      // MODE bit 0 enables rising, bit 1 falling; the new level tells which edge it was.
      ev_d[ch] = (trans[ch] & (s2_q[ch] ? mode_q[ch][0] : mode_q[ch][1])) | sw_trig[ch];
      status_d[ch] = (status_q[ch] & ~st_clr[ch]) | ev_q[ch];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        A_CFG_LO, A_CFG_HI: begin
          rdata[3:0] = src_q[addr[2]];
          rdata[5:4] = mode_q[addr[2]];
`ifdef TIMER_EVT_FILTER_EN
          rdata[8 +: FILT_W] = flen_q[addr[2]];
`endif
        end
        A_STATUS: rdata[1:0] = status_q;
        default:  rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA_o  = rdata;
  assign apb.PREADY_o  = 1'b1;
  assign apb.PSLVERR_o = 1'b0;
  assign event_lo_o    = ev_q[0];
  assign event_hi_o    = ev_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q    <= '0;
      mode_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      f_q      <= '0;
      warm_q   <= {2'd2, 2'd2};
      ev_q     <= '0;
      status_q <= '0;
`ifdef TIMER_EVT_FILTER_EN
      flen_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      src_q    <= src_d;
      mode_q   <= mode_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      f_q      <= f_d;
      warm_q   <= warm_d;
      ev_q     <= ev_d;
      status_q <= status_d;
`ifdef TIMER_EVT_FILTER_EN
      flen_q   <= flen_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_timer_event_cond.sv
// Directed bench for apb_timer_event_cond; expectations follow the build's TIMER_EVT_FILTER_EN setting.
module tb_apb_timer_event_cond;

`ifdef TIMER_EVT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ext;
  logic       ev_lo;
  logic       ev_hi;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_lo  = 0;
  int         n_hi  = 0;

  apb_timer_event_cond_if #(.APB_ADDR_WIDTH(12)) bus ();

  apb_timer_event_cond #(.APB_ADDR_WIDTH(12), .N_EXT(4), .FILT_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .apb        (bus),
    .ext_evt_i  (ext),
    .event_lo_o (ev_lo),
    .event_hi_o (ev_hi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ev_lo) n_lo <= n_lo + 1;
    if (ev_hi) n_hi <= n_hi + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    bus.PSEL_i = 1'b1; bus.PWRITE_i = 1'b1; bus.PENABLE_i = 1'b0;
    bus.PADDR_i = a; bus.PWDATA_i = d;
    tick();
    bus.PENABLE_i = 1'b1;
    tick();
    bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    bus.PSEL_i = 1'b1; bus.PWRITE_i = 1'b0; bus.PENABLE_i = 1'b0;
    bus.PADDR_i = a;
    tick();
    bus.PENABLE_i = 1'b1;
    #1;
    d = bus.PRDATA_o;
    tick();
    bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    ext = 4'h0;
    bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
    bus.PADDR_i = '0; bus.PWDATA_i = '0;
    ticks(3);
    n_vec++; if (ev_lo !== 1'b0) begin n_err++; $display("FAIL reset_ev_lo: got %b want 0", ev_lo); end
    n_vec++; if (ev_hi !== 1'b0) begin n_err++; $display("FAIL reset_ev_hi: got %b want 0", ev_hi); end
    n_vec++; if (bus.PRDATA_o !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h want 0", bus.PRDATA_o); end
    n_vec++; if (bus.PREADY_o !== 1'b1) begin n_err++; $display("FAIL pready: got %b want 1", bus.PREADY_o); end
    n_vec++; if (bus.PSLVERR_o !== 1'b0) begin n_err++; $display("FAIL pslverr: got %b want 0", bus.PSLVERR_o); end
    rst = 1'b0;
    tick();
    apb_read(12'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_cfg_lo: got %h want 0", rd); end
    apb_read(12'h4, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_cfg_hi: got %h want 0", rd); end
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", rd); end
  endtask

  task automatic test_regmap();
    logic [31:0] rd;
    apb_write(12'h4, 32'hFFFF_FFFF);
    apb_read(12'h4, rd);
    n_vec++; if (rd !== (FILT ? 32'h0000_FF3F : 32'h0000_003F)) begin
      n_err++; $display("FAIL cfg_unused_bits: got %h want %h", rd, (FILT ? 32'h0000_FF3F : 32'h0000_003F)); end
    apb_write(12'h2, 32'hFFFF_FFFF);
    apb_read(12'h2, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL other_addr_read: got %h want 0", rd); end
    apb_read(12'h8, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL swtrig_read: got %h want 0", rd); end
    apb_read(12'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL cfg_lo_untouched: got %h want 0", rd); end
    apb_write(12'h4, 32'h0);
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL regmap_status: got %h want 0", rd); end
  endtask

  task automatic test_rise_flen0();
    logic [31:0] rd;
    int base;
    apb_write(12'h0, 32'h0000_0011);
    ticks(4);
    base = n_lo;
    ext[1] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_vec++; if (ev_lo !== (e == 3)) begin
        n_err++; $display("FAIL rise_edge%0d: got %b want %b", e, ev_lo, (e == 3)); end
    end
    ext[1] = 1'b0;
    ticks(6);
    n_vec++; if (n_lo - base !== 1) begin n_err++; $display("FAIL rise_pulse_count: got %0d want 1", n_lo - base); end
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL rise_status: got %h want 1", rd); end
    apb_write(12'hC, 32'h1);
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rise_status_clr: got %h want 0", rd); end
  endtask

  task automatic test_filter();
    logic [31:0] rd;
    int base;
    int first;
    apb_write(12'h4, 32'h0000_0432);
    apb_read(12'h4, rd);
    n_vec++; if (rd !== (FILT ? 32'h432 : 32'h32)) begin
      n_err++; $display("FAIL filt_cfg_read: got %h want %h", rd, (FILT ? 32'h432 : 32'h32)); end
    ticks(4);
    base = n_hi;
    ext[2] = 1'b1;
    ticks(3);
    ext[2] = 1'b0;
    ticks(10);
    n_vec++; if (n_hi - base !== (FILT ? 0 : 2)) begin
      n_err++; $display("FAIL glitch_events: got %0d want %0d", n_hi - base, (FILT ? 0 : 2)); end
    base = n_hi;
    first = 0;
    ext[2] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (ev_hi && first == 0) first = e;
    end
    n_vec++; if (first !== (FILT ? 7 : 3)) begin
      n_err++; $display("FAIL filt_latency: got %0d want %0d", first, (FILT ? 7 : 3)); end
    n_vec++; if (n_hi - base !== 1) begin n_err++; $display("FAIL filt_pulse_count: got %0d want 1", n_hi - base); end
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL filt_status: got %h want 2", rd); end
    apb_write(12'hC, 32'h2);
  endtask

  task automatic test_cfg_switch();
    logic [31:0] rd;
    int base;
    ext[3] = 1'b1;
    ticks(3);
    base = n_lo;
    apb_write(12'h0, 32'h0000_0013);
    ticks(10);
    n_vec++; if (n_lo - base !== 0) begin n_err++; $display("FAIL switch_spurious: got %0d want 0", n_lo - base); end
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL switch_status: got %h want 0", rd); end
  endtask

  task automatic test_sw_hw_same();
    logic [31:0] rd;
    int base_l;
    int base_h;
    apb_write(12'h0, 32'h0000_0011);
    ticks(4);
    base_l = n_lo;
    base_h = n_hi;
    ext[1] = 1'b1;
    tick();
    apb_write(12'h8, 32'h3);
    n_vec++; if ({ev_hi, ev_lo} !== 2'b11) begin n_err++; $display("FAIL sw_hw_high: got %b want 11", {ev_hi, ev_lo}); end
    tick();
    n_vec++; if ({ev_hi, ev_lo} !== 2'b00) begin n_err++; $display("FAIL sw_hw_low: got %b want 00", {ev_hi, ev_lo}); end
    ticks(4);
    n_vec++; if (n_lo - base_l !== 1) begin n_err++; $display("FAIL sw_hw_lo_count: got %0d want 1", n_lo - base_l); end
    n_vec++; if (n_hi - base_h !== 1) begin n_err++; $display("FAIL sw_hi_count: got %0d want 1", n_hi - base_h); end
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h3) begin n_err++; $display("FAIL sw_hw_status: got %h want 3", rd); end
    apb_write(12'hC, 32'h3);
  endtask

  task automatic test_status_race();
    logic [31:0] rd;
    int base;
    ext[1] = 1'b0;
    ticks(5);
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL race_pre_status: got %h want 0", rd); end
    base = n_lo;
    ext[1] = 1'b1;
    ticks(2);
    apb_write(12'hC, 32'h1);
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL race_set_wins: got %h want 1", rd); end
    n_vec++; if (n_lo - base !== 1) begin n_err++; $display("FAIL race_pulse_count: got %0d want 1", n_lo - base); end
    apb_write(12'hC, 32'h1);
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL race_cleared: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid_filter();
    logic [31:0] rd;
    int base;
    apb_write(12'h0, 32'h0000_0A10);
    apb_read(12'h0, rd);
    n_vec++; if (rd !== (FILT ? 32'hA10 : 32'h10)) begin
      n_err++; $display("FAIL rstmid_cfg_read: got %h want %h", rd, (FILT ? 32'hA10 : 32'h10)); end
    ticks(4);
    ext[0] = 1'b1;
    ticks(8);
    base = n_lo;
    rst = 1'b1;
    #1;
    n_vec++; if ({ev_hi, ev_lo} !== 2'b00) begin n_err++; $display("FAIL rstmid_outputs: got %b want 00", {ev_hi, ev_lo}); end
    n_vec++; if (bus.PRDATA_o !== 32'h0) begin n_err++; $display("FAIL rstmid_prdata: got %h want 0", bus.PRDATA_o); end
    ticks(2);
    rst = 1'b0;
    ticks(5);
    n_vec++; if (n_lo - base !== 0) begin n_err++; $display("FAIL rstmid_no_event: got %0d want 0", n_lo - base); end
    apb_read(12'h0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rstmid_cfg_cleared: got %h want 0", rd); end
    apb_read(12'hC, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rstmid_status: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_rise_flen0();
    test_filter();
    test_cfg_switch();
    test_sw_hw_same();
    test_status_race();
    test_reset_mid_filter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
